// File: rtl/lzs_token_dec.sv
// lzs_token_dec: decodes LZS literal / match / end-marker codes from the aligner's 13-bit MSB-first window.
// Latency: token register loads on the edge of the completing ack; tok_valid is seen one cycle later.
// Backpressure: token-completing pieces wait for a free token slot; header pieces are consumed regardless.
module lzs_token_dec #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [12:0]      stream_data,
  input  logic             stream_valid,
  input  logic             stream_done,
  output logic [3:0]       stream_width,
  output logic             stream_ack,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic             tok_match,
  output logic [7:0]       tok_literal,
  output logic [10:0]      tok_offset,
  output logic [LEN_W-1:0] tok_length,
  output logic             tok_end,
  output logic             dec_err
);

  typedef enum logic [1:0] {S_TOK, S_LEN, S_EXT, S_END} state_t;

  // Largest encodable length, one bit wider so the extension sum can be range-checked.
  localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};

  state_t           state_q, state_d, dec_nxt;
  logic [10:0]      off_q, off_d, dec_off;
  logic [LEN_W-1:0] acc_q, acc_d, dec_acc, dec_len;
  logic             dec_err_q, dec_err_d;
  logic             tok_valid_q, tok_valid_d, tok_match_q, tok_match_d, tok_end_q, tok_end_d;
  logic [7:0]       tok_literal_q, tok_literal_d, dec_lit;
  logic [10:0]      tok_offset_q, tok_offset_d;
  logic [LEN_W-1:0] tok_length_q, tok_length_d;
  logic [3:0]       dec_width, nib;
  logic             dec_cplt, dec_bad, dec_match, dec_end, dec_off_ld, dec_acc_ld;
  logic [LEN_W:0]   ext_sum;
  logic             slot_free, can_go, ack, trunc, load;

  // An all-ones nibble adds 15 and a terminal nibble adds n, so one sum covers both cases.
  assign nib     = stream_data[12:9];
  assign ext_sum = {1'b0, acc_q} + (LEN_W+1)'(nib);

  // Decode the piece at the head of the window for the current parse state.
  always_comb begin
    dec_width  = 4'd0;
    dec_cplt   = 1'b0;
    dec_bad    = 1'b0;
    dec_nxt    = state_q;
    dec_match  = 1'b0;
    dec_end    = 1'b0;
    dec_lit    = 8'd0;
    dec_len    = '0;
    dec_off_ld = 1'b0;
    dec_off    = 11'd0;
    dec_acc_ld = 1'b0;
    dec_acc    = '0;
    case (state_q)
      S_TOK: begin
        if (!stream_data[12]) begin
          dec_width = 4'd9;
          dec_cplt  = 1'b1;
          dec_lit   = stream_data[11:4];
        end else if (stream_data[11]) begin
          dec_width = 4'd9;
          if (stream_data[10:4] == 7'd0) begin
            dec_cplt = 1'b1;
            dec_end  = 1'b1;
            dec_nxt  = S_END;
          end else begin
            dec_off_ld = 1'b1;
            dec_off    = {4'd0, stream_data[10:4]};
            dec_nxt    = S_LEN;
          end
        end else begin
          dec_width  = 4'd13;
          dec_bad    = (stream_data[10:0] == 11'd0);
          dec_off_ld = 1'b1;
          dec_off    = stream_data[10:0];
          dec_nxt    = S_LEN;
        end
      end
      S_LEN: begin
        if (stream_data[12:11] != 2'b11) begin
          dec_width = 4'd2;
          dec_cplt  = 1'b1;
          dec_match = 1'b1;
          dec_len   = LEN_W'(2) + LEN_W'(stream_data[12:11]);
          dec_nxt   = S_TOK;
        end else if (stream_data[10:9] != 2'b11) begin
          dec_width = 4'd4;
          dec_cplt  = 1'b1;
          dec_match = 1'b1;
          dec_len   = LEN_W'(5) + LEN_W'(stream_data[10:9]);
          dec_nxt   = S_TOK;
        end else begin
          dec_width  = 4'd4;
          dec_acc_ld = 1'b1;
          dec_acc    = LEN_W'(8);
          dec_nxt    = S_EXT;
        end
      end
      S_EXT: begin
        dec_width = 4'd4;
        dec_bad   = (ext_sum > LEN_MAX);
        if (nib == 4'hF) begin
          dec_acc_ld = 1'b1;
          dec_acc    = ext_sum[LEN_W-1:0];
        end else begin
          dec_cplt  = 1'b1;
          dec_match = 1'b1;
          dec_len   = ext_sum[LEN_W-1:0];
          dec_nxt   = S_TOK;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs: consume the piece only when it is legal and, if it completes a token, a slot is free.
  always_comb begin
    slot_free    = ~tok_valid_q | tok_ready;
    can_go       = rst_n & ce & stream_valid & ~dec_err_q & (state_q != S_END);
    ack          = can_go & ~dec_bad & (~dec_cplt | slot_free);
    stream_ack   = ack;
    stream_width = ack ? dec_width : 4'd0;
    load         = ack & dec_cplt;
    trunc        = stream_done & ~stream_valid & ((state_q == S_LEN) | (state_q == S_EXT));
    dec_err_d    = dec_err_q | (can_go & dec_bad) | trunc;
  end

  // Next state: advance on ack; the end state waits for ce to drop before parsing again.
  always_comb begin
    state_d = state_q;
    if (state_q == S_END) begin
      if (!ce) state_d = S_TOK;
    end else if (ack) begin
      state_d = dec_nxt;
    end
  end

  // Header registers and the output token register (drain and reload may share an edge).
  always_comb begin
    off_d         = (ack & dec_off_ld) ? dec_off : off_q;
    acc_d         = (ack & dec_acc_ld) ? dec_acc : acc_q;
    tok_valid_d   = tok_valid_q;
    tok_match_d   = tok_match_q;
    tok_literal_d = tok_literal_q;
    tok_offset_d  = tok_offset_q;
    tok_length_d  = tok_length_q;
    tok_end_d     = tok_end_q;
    if (load) begin
      tok_valid_d   = 1'b1;
      tok_match_d   = dec_match;
      tok_literal_d = dec_lit;
      tok_offset_d  = dec_match ? off_q : 11'd0;
      tok_length_d  = dec_len;
      tok_end_d     = dec_end;
    end else if (tok_valid_q & tok_ready) begin
      tok_valid_d   = 1'b0;
      tok_match_d   = 1'b0;
      tok_literal_d = 8'd0;
      tok_offset_d  = 11'd0;
      tok_length_d  = '0;
      tok_end_d     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_TOK;
    else        state_q <= state_d;
  end

  // Datapath registers; reset drops any partial header and pending token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_q         <= 11'd0;
      acc_q         <= '0;
      dec_err_q     <= 1'b0;
      tok_valid_q   <= 1'b0;
      tok_match_q   <= 1'b0;
      tok_literal_q <= 8'd0;
      tok_offset_q  <= 11'd0;
      tok_length_q  <= '0;
      tok_end_q     <= 1'b0;
    end else begin
      off_q         <= off_d;
      acc_q         <= acc_d;
      dec_err_q     <= dec_err_d;
      tok_valid_q   <= tok_valid_d;
      tok_match_q   <= tok_match_d;
      tok_literal_q <= tok_literal_d;
      tok_offset_q  <= tok_offset_d;
      tok_length_q  <= tok_length_d;
      tok_end_q     <= tok_end_d;
    end
  end

  assign tok_valid   = tok_valid_q;
  assign tok_match   = tok_match_q;
  assign tok_literal = tok_literal_q;
  assign tok_offset  = tok_offset_q;
  assign tok_length  = tok_length_q;
  assign tok_end     = tok_end_q;
  assign dec_err     = dec_err_q;

endmodule

// File: doc/lzs_token_dec.md
Name: lzs_token_dec

Overview:
- LZS token parser sitting directly downstream of the bit-stream aligner.
- Consumes the aligner's 13-bit MSB-first look-ahead window, decodes LZS literal, match and end-marker codes, and tells the aligner how many bits were used (width plus ack).
- Emits one registered token per literal, match or end marker to the history/copy engine through a valid/ready handshake.

Parameters:
LEN_W, 12, width of the decoded match-length field; maximum representable length is 2^LEN_W-1.

Ports:
clk  in  1  clock
rst_n  in  1  reset
ce  in  1  unit enable; 0 = idle, no bits consumed
stream_data  in  13  look-ahead window; bit 12 is the next unconsumed stream bit
stream_valid  in  1  stream_data holds at least 13 valid bits
stream_done  in  1  aligner reached the last source word
stream_width  out  4  bits consumed this cycle; meaningful only with stream_ack
stream_ack  out  1  consume stream_width bits at this clock edge
tok_valid  out  1  token register full
tok_ready  in  1  downstream accepts the token at this edge
tok_match  out  1  1 = match token, 0 = literal token
tok_literal  out  8  literal byte
tok_offset  out  11  match offset, 1..2047
tok_length  out  LEN_W  match length, >=2
tok_end  out  1  end-marker token; other token fields are 0
dec_err  out  1  sticky format error

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=S_TOK; all tok_* outputs 0; dec_err=0; stream_ack=0; stream_width=0.
- stream_ack and stream_width are combinational from state and stream_data.
- stream_ack is asserted only when all of the following hold: ce=1, stream_valid=1, dec_err=0, state is not S_END.
- A piece that completes a token is also gated by slot_free = ~tok_valid | tok_ready.
- Token register loads on the clock edge of the completing ack. tok_valid rises the next cycle, so latency is 1 cycle from the final ack.
- Token register clears on tok_valid & tok_ready unless it is reloaded at the same edge. Simultaneous drain and load is allowed, giving 1 token/cycle sustained.
- Header fields (offset, partial length) are held in internal registers between pieces.
- S_TOK, literal (d[12]=0):
  - width 9, needs slot_free.
  - Emit tok_match=0, tok_literal=d[11:4]. Stay in S_TOK.
- S_TOK, short offset (d[12:11]=11):
  - off=d[10:4], width 9.
  - If off=0, this is the end marker (needs slot_free): emit tok_end=1 and go to S_END.
  - Otherwise latch off and go to S_LEN.
- S_TOK, long offset (d[12:11]=10):
  - off=d[10:0], width 13, go to S_LEN.
  - off=0: set dec_err and send no ack.
- S_LEN:
  - d[12:11]=00/01/10 gives len 2/3/4, width 2, emit match, go to S_TOK.
  - d[12:9]=1100/1101/1110 gives len 5/6/7, width 4, emit match, go to S_TOK.
  - d[12:9]=1111: width 4, acc=8, go to S_EXT (no slot needed).
- S_EXT, nibble n=d[12:9]:
  - n=1111: acc+=15, width 4, stay in S_EXT.
  - Otherwise: len=acc+n, width 4, emit match, go to S_TOK.
- Length overflow: if acc+15 or acc+n exceeds 2^LEN_W-1, set dec_err and send no ack.
- S_END: sends no acks. Returns to S_TOK when ce=0.
- ce deasserted mid-token: state and header registers are held; parsing resumes when ce returns.
- dec_err: once set, all acks stop and the token register still drains. Cleared only by reset.
- stream_done=1 while in S_LEN or S_EXT with stream_valid=0 is a truncated match: set dec_err.
- Reset mid-token discards partial header and any pending token.

Test Plan:
- Literal: d=13'b0_01000001_0000 with tok_ready=1 -> ack width 9; next cycle tok_valid=1, tok_match=0, tok_literal=0x41.
- Short match: d=1_1_0000101_xx, then 00_x -> acks width 9 then width 2; token has offset 5, length 2.
- Long match with extension: 1_0_10000000000, then 1111, 1111, 0011 -> widths 13,4,4,4; token has offset 1024, length 26 (8+15+3).
- Back-pressure: two literals with tok_ready=0 -> first loads and the second piece is not acked. Raising tok_ready -> both tokens delivered in order, one per cycle.
- End marker: 1_1_0000000 -> width 9; tok_end=1; no further acks while ce=1. Dropping ce returns the block to S_TOK.
- Errors:
  - Long offset 0 -> dec_err=1 and acks stop.
  - LEN_W=4 with extension nibbles 1111,0001 -> acc=23, which exceeds 15, so dec_err=1.
  - rst_n low for 1 cycle -> all outputs 0.
